// File: rtl/mc_cu_pkg.sv
// Shared types and encodings for the multi-cycle control unit: FSM states,
// opcode map (low 4 bits) and PC operation codes.
package mc_cu_pkg;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_LOAD  = 4'h1;
  localparam logic [3:0] OP_STORE = 4'h2;
  localparam logic [3:0] OP_ADDI  = 4'h3;
  localparam logic [3:0] OP_JMP   = 4'h8;
  localparam logic [3:0] OP_BRZ   = 4'h9;
  localparam logic [3:0] OP_HALT  = 4'hF;

  localparam logic [1:0] PC_HOLD  = 2'b00;
  localparam logic [1:0] PC_INC   = 2'b01;
  localparam logic [1:0] PC_JUMP  = 2'b10;
  localparam logic [1:0] PC_CLEAR = 2'b11;

  // 0100..0111 are the register-register ALU ops
  function automatic logic is_alu_op(input logic [3:0] op);
    return op[3:2] == 2'b01;
  endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// Memory wait-state counter. expired flags the MEM_TIMEOUT-th consecutive
// not-ready cycle; a zero timeout disables the timer entirely.
module mc_wait_timer #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  generate
    if (MEM_TIMEOUT == 0) begin : g_off
      assign expired = 1'b0;
    end else begin : g_cnt
      localparam int CW_RAW = $clog2(MEM_TIMEOUT + 1);
      localparam int CW     = (CW_RAW < 1) ? 1 : CW_RAW;
      localparam logic [CW-1:0] LAST = CW'(MEM_TIMEOUT - 1);

      logic [CW-1:0] cnt;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                        cnt <= '0;
        else if (clear)                    cnt <= '0;
        else if (count_en && cnt != '1)    cnt <= cnt + 1'b1;
      end

      assign expired = count_en && (cnt == LAST);
    end
  endgenerate

endmodule

// File: rtl/mc_control_unit.sv
// Multi-cycle control unit: FETCH/DECODE/EXEC/MEM/WB sequencing with memory
// handshake timeout, flag-conditional branch, immediate ALU ops and sticky halt.
module mc_control_unit
  import mc_cu_pkg::*;
#(
  parameter int OPCODE_W    = 4,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                flag,
  input  logic                mem_ready,
  output logic                inst_wr,
  output logic                decoder_en,
  output logic                reg_en,
  output logic                imm_en,
  output logic                rD_wr,
  output logic                mem_rd,
  output logic                mem_wr,
  output logic                adrs_ctrl,
  output logic [1:0]          pc_op,
  output logic                halted,
  output logic                timeout_err
);

  state_t     state;
  logic [3:0] op_q;
  logic [3:0] op_dec;
  logic       tmr_expired;

  // Any set bit above bit 3 turns the instruction into a NOP.
  assign op_dec = ((opcode >> 4) != '0) ? OP_NOP : opcode[3:0];

  mc_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_wait (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (state != S_MEM),
    .count_en (state == S_MEM && !mem_ready),
    .expired  (tmr_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      op_q        <= OP_NOP;
      timeout_err <= 1'b0;
    end else begin
      case (state)
        S_IDLE:   state <= S_FETCH;
        S_FETCH:  state <= S_DECODE;
        S_DECODE: begin
          op_q <= op_dec;
          if (op_dec == OP_LOAD || op_dec == OP_STORE) state <= S_MEM;
          else if (op_dec == OP_HALT)                  state <= S_HALT;
          else                                         state <= S_EXEC;
        end
        S_EXEC:   state <= (is_alu_op(op_q) || op_q == OP_ADDI) ? S_WB : S_FETCH;
        S_MEM: begin
          // a same-cycle ready beats the timeout
          if (mem_ready)        state <= (op_q == OP_LOAD) ? S_WB : S_FETCH;
          else if (tmr_expired) begin
            state       <= S_HALT;
            timeout_err <= 1'b1;
          end
        end
        S_WB:     state <= S_FETCH;
        S_HALT:   state <= S_HALT;
        default:  state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    inst_wr    = 1'b0;
    decoder_en = 1'b0;
    reg_en     = 1'b0;
    imm_en     = 1'b0;
    rD_wr      = 1'b0;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    adrs_ctrl  = 1'b0;
    pc_op      = PC_HOLD;
    halted     = 1'b0;
    case (state)
      S_IDLE:   pc_op = PC_CLEAR;
      S_FETCH: begin
        inst_wr = 1'b1;
        pc_op   = PC_INC;
      end
      S_DECODE: decoder_en = 1'b1;
      S_EXEC: begin
        if (is_alu_op(op_q)) reg_en = 1'b1;
        if (op_q == OP_ADDI) begin
          reg_en = 1'b1;
          imm_en = 1'b1;
        end
        if (op_q == OP_JMP || (op_q == OP_BRZ && flag)) pc_op = PC_JUMP;
      end
      S_MEM: begin
        adrs_ctrl = 1'b1;
        reg_en    = 1'b1;
        mem_rd    = (op_q == OP_LOAD);
        mem_wr    = (op_q == OP_STORE);
      end
      S_WB: begin
        rD_wr  = 1'b1;
        imm_en = (op_q == OP_ADDI);
      end
      S_HALT:   halted = 1'b1;
      default:  pc_op = PC_HOLD;
    endcase
  end

endmodule

// File: tb/tb_mc_control_unit.sv
// Cycle-level scoreboard bench for mc_control_unit (OPCODE_W=5, MEM_TIMEOUT=4).
module tb_mc_control_unit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] opcode = '0;
  logic       flag = 1'b0;
  logic       mem_ready = 1'b0;
  logic inst_wr, decoder_en, reg_en, imm_en, rD_wr, mem_rd, mem_wr, adrs_ctrl;
  logic [1:0] pc_op;
  logic halted, timeout_err;

  mc_control_unit #(.OPCODE_W(5), .MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .flag(flag), .mem_ready(mem_ready),
    .inst_wr(inst_wr), .decoder_en(decoder_en), .reg_en(reg_en), .imm_en(imm_en),
    .rD_wr(rD_wr), .mem_rd(mem_rd), .mem_wr(mem_wr), .adrs_ctrl(adrs_ctrl),
    .pc_op(pc_op), .halted(halted), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // {inst_wr,decoder_en,reg_en,imm_en,rD_wr,mem_rd,mem_wr,adrs_ctrl,pc_op,halted,timeout_err}
  logic [11:0] obs;
  assign obs = {inst_wr, decoder_en, reg_en, imm_en, rD_wr, mem_rd, mem_wr, adrs_ctrl,
                pc_op, halted, timeout_err};

  localparam logic [11:0] E_IDLE  = 12'b0000_0000_1100;
  localparam logic [11:0] E_FETCH = 12'b1000_0000_0100;
  localparam logic [11:0] E_DEC   = 12'b0100_0000_0000;
  localparam logic [11:0] E_ZERO  = 12'b0000_0000_0000;
  localparam logic [11:0] E_ALU   = 12'b0010_0000_0000;
  localparam logic [11:0] E_ADDI  = 12'b0011_0000_0000;
  localparam logic [11:0] E_JMP   = 12'b0000_0000_1000;
  localparam logic [11:0] E_MLD   = 12'b0010_0101_0000;
  localparam logic [11:0] E_MST   = 12'b0010_0011_0000;
  localparam logic [11:0] E_WB    = 12'b0000_1000_0000;
  localparam logic [11:0] E_WBI   = 12'b0001_1000_0000;
  localparam logic [11:0] E_HALT  = 12'b0000_0000_0010;
  localparam logic [11:0] E_HTO   = 12'b0000_0000_0011;

  typedef struct {
    string       tag;
    logic [11:0] v;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, want, $time);
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk(e.tag, 32'(obs), 32'(e.v));
    end
  end

  // Drive one cycle's inputs and queue that cycle's expected outputs.
  task automatic step(input logic [4:0] op, input logic f, input logic r,
                      input logic [11:0] v, input string tag);
    opcode    = op;
    flag      = f;
    mem_ready = r;
    sb.push_back('{tag, v});
    @(posedge clk);
    #1;
  endtask

  task automatic fd(input logic [4:0] op, input string tag);
    step(op, 1'b0, 1'b0, E_FETCH, {tag, "_f"});
    step(op, 1'b0, 1'b0, E_DEC,   {tag, "_d"});
  endtask

  task automatic reset_cycles(input int n, input string tag);
    rst_n = 1'b0;
    for (int i = 0; i < n; i++) step(5'h00, 1'b0, 1'b0, E_IDLE, tag);
    rst_n = 1'b1;
    step(5'h00, 1'b0, 1'b0, E_IDLE, {tag, "_rel"});
  endtask

  initial begin
    @(posedge clk);
    #1;
    reset_cycles(3, "rst");

    // NOP loop: 3-cycle period
    for (int i = 0; i < 2; i++) begin
      fd(5'h00, "nop");
      step(5'h00, 1'b0, 1'b0, E_ZERO, "nop_x");
    end
    // unmapped low code and set upper bit both decode as NOP
    fd(5'h0A, "nopa");
    step(5'h0A, 1'b0, 1'b0, E_ZERO, "nopa_x");
    fd(5'h11, "nopu");
    step(5'h11, 1'b0, 1'b0, E_ZERO, "nopu_x");

    // ALU op; opcode changes to HALT after DECODE must be ignored
    fd(5'h05, "alu");
    step(5'h0F, 1'b0, 1'b0, E_ALU, "alu_x");
    step(5'h0F, 1'b0, 1'b0, E_WB,  "alu_wb");

    fd(5'h03, "addi");
    step(5'h03, 1'b0, 1'b0, E_ADDI, "addi_x");
    step(5'h03, 1'b0, 1'b0, E_WBI,  "addi_wb");

    fd(5'h08, "jmp");
    step(5'h08, 1'b0, 1'b0, E_JMP, "jmp_x");

    fd(5'h09, "brz1");
    step(5'h09, 1'b1, 1'b0, E_JMP, "brz1_x");
    fd(5'h09, "brz0");
    step(5'h09, 1'b0, 1'b0, E_ZERO, "brz0_x");

    // LOAD, two wait states
    fd(5'h01, "ld");
    step(5'h01, 1'b0, 1'b0, E_MLD, "ld_m1");
    step(5'h01, 1'b0, 1'b0, E_MLD, "ld_m2");
    step(5'h01, 1'b0, 1'b1, E_MLD, "ld_m3");
    step(5'h01, 1'b0, 1'b0, E_WB,  "ld_wb");

    // STORE, zero wait
    fd(5'h02, "st0");
    step(5'h02, 1'b0, 1'b1, E_MST, "st0_m");

    // STORE, ready on the 4th MEM cycle wins over the timeout
    fd(5'h02, "st4");
    for (int i = 0; i < 3; i++) step(5'h02, 1'b0, 1'b0, E_MST, "st4_w");
    step(5'h02, 1'b0, 1'b1, E_MST, "st4_m4");
    fd(5'h00, "after_st4");
    step(5'h00, 1'b0, 1'b0, E_ZERO, "after_st4_x");

    // asynchronous reset in MEM drops strobes without waiting for a clock
    fd(5'h01, "ldr");
    opcode = 5'h01; mem_ready = 1'b0;
    #2;
    chk("mid_mem", 32'(obs), 32'(E_MLD));
    rst_n = 1'b0;
    #1;
    chk("async_rst", 32'(obs), 32'(E_IDLE));
    @(posedge clk);
    #1;
    reset_cycles(1, "rst2");

    // the aborted LOAD must not leave the wait counter advanced
    fd(5'h02, "st4b");
    for (int i = 0; i < 3; i++) step(5'h02, 1'b0, 1'b0, E_MST, "st4b_w");
    step(5'h02, 1'b0, 1'b1, E_MST, "st4b_m4");

    // HALT opcode: sticky, no timeout error
    fd(5'h0F, "hlt");
    for (int i = 0; i < 3; i++) step(5'h00, 1'b1, 1'b1, E_HALT, "hlt_s");
    reset_cycles(1, "rst3");

    // STORE timeout: 4 MEM cycles then sticky halt with error
    fd(5'h02, "sto");
    for (int i = 0; i < 4; i++) step(5'h02, 1'b0, 1'b0, E_MST, "sto_w");
    step(5'h02, 1'b0, 1'b1, E_HTO, "sto_h1");
    step(5'h00, 1'b0, 1'b1, E_HTO, "sto_h2");
    step(5'h05, 1'b1, 1'b0, E_HTO, "sto_h3");
    reset_cycles(2, "rst4");
    fd(5'h00, "post");
    step(5'h00, 1'b0, 1'b0, E_ZERO, "post_x");

    @(negedge clk);
    chk("sb_drain", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
